// File: rtl/mips_ifetch_prefetch_queue.sv
// rtl/mips_ifetch_prefetch_queue.sv - instruction-fetch prefetch queue feeding the MIPS32 IF/ID latch
// Credit-limited requests to in-order imem, {IR, NPC} FIFO, redirect flush with stale-response dropping.
module mips_ifetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] NOP_WORD = 32'hF8000000
) (
   input  logic              clk1,
   input  logic              reset,
   input  logic              halt,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [31:0]       ir_data,
   output logic [31:0]       ir_npc
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic {FETCH, STALL} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
   logic [31:0]       npc_hold_q;
   logic [31:0]       data_q [DEPTH];
   logic [ADDR_W:0]   npc_q  [DEPTH];

   logic              issue, push, pop;
   logic [CW:0]       credit_used;

   always_comb begin
      credit_used    = {1'b0, count_q} + {1'b0, outstanding_q};
      imem_req_valid = !reset && (state_q == FETCH) && !halt && !redirect_valid
                       && (credit_used < DEPTH_W);
      imem_req_addr  = fetch_pc_q;
      issue          = imem_req_valid && imem_req_ready;
      ir_valid       = (count_q != '0);
      // npc_hold_q keeps ir_npc stable across empty periods, including after a flush
      ir_data        = ir_valid ? data_q[rd_ptr_q] : NOP_WORD;
      ir_npc         = ir_valid ? 32'(npc_q[rd_ptr_q]) : npc_hold_q;
      push           = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
      pop            = ir_valid && ir_ready && !redirect_valid;
      outstanding_d  = outstanding_q + CW'(issue) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         // every request still in flight after this cycle belongs to the old path
         drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
      end else begin
         count_d    = count_q + CW'(push) - CW'(pop);
         wr_ptr_d   = wr_ptr_q + PW'(push);
         rd_ptr_d   = rd_ptr_q + PW'(pop);
         fetch_pc_d = fetch_pc_q + ADDR_W'(issue);
         resp_pc_d  = resp_pc_q + ADDR_W'(push);
         drop_cnt_d = drop_cnt_q - CW'(imem_rsp_valid && (drop_cnt_q != '0));
      end
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         state_q       <= FETCH;
         fetch_pc_q    <= '0;
         resp_pc_q     <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         npc_hold_q    <= '0;
      end else begin
         if (state_q == FETCH && halt) begin
            state_q <= STALL;
         end else if (state_q == STALL && !halt) begin
            state_q <= FETCH;
         end
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         npc_hold_q    <= ir_npc;
      end
   end

   always_ff @(posedge clk1) begin
      if (!reset && push) begin
         data_q[wr_ptr_q] <= imem_rsp_data;
         npc_q[wr_ptr_q]  <= {1'b0, resp_pc_q} + (ADDR_W+1)'(1);
      end
   end
endmodule

// File: doc/mips_ifetch_prefetch_queue.md
Name: mips_ifetch_prefetch_queue

Overview:
Instruction-fetch front end for the 5-stage in-order MIPS32 pipeline. It sits directly upstream of the IF/ID latch.
- Issues word-addressed requests to a variable-latency, in-order instruction memory.
- Buffers returned words with their NPC in a small FIFO.
- Hands {IR, NPC} to the IF stage through a valid/ready handshake.
- On a taken-branch redirect from EX/MEM, flushes the FIFO and discards stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >=2.
ADDR_W, 10, word-address width (1024-word memory).
NOP_WORD, 32'hF8000000, value driven on ir_data when no valid entry.

Ports:
clk1  in  1  clock; all state on posedge clk1.
reset  in  1  synchronous, active-high.
halt  in  1  level; when 1, no new requests are issued.
redirect_valid  in  1  one-cycle pulse: taken branch.
redirect_pc  in  ADDR_W  branch target word address.
imem_req_valid  out  1  request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  ADDR_W  requested word address.
imem_rsp_valid  in  1  response valid (in request order, latency >=1).
imem_rsp_data  in  32  instruction word.
ir_valid  out  1  head entry valid.
ir_ready  in  1  IF stage consumes head.
ir_data  out  32  head instruction word.
ir_npc  out  32  head word address + 1, zero-extended.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk1.
- Reset values:
  - fetch_pc = 0, resp_pc = 0.
  - FIFO empty, outstanding = 0, drop_cnt = 0, state = FETCH.
  - imem_req_valid = 0, ir_valid = 0, ir_data = NOP_WORD, ir_npc = 0.
- Reset mid-operation abandons in-flight requests. Responses arriving after reset are not dropped; the memory is also reset by the same signal.
- State machine:
  - FETCH -> STALL when halt = 1.
  - STALL -> FETCH when halt = 0.
  - Redirect is legal in both states and does not change state.
- Issue:
  - imem_req_valid = (state == FETCH) && !halt && !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On req_valid && req_ready: fetch_pc += 1 (wraps mod 2^ADDR_W), outstanding += 1.
- Credit rule: count + outstanding never exceeds DEPTH, so pushes never overflow.
- Response handling:
  - Each rsp_valid decrements outstanding.
  - If drop_cnt > 0: the response is discarded and drop_cnt -= 1.
  - Otherwise: push {rsp_data, resp_pc + 1}, then resp_pc += 1 (wraps).
- Output:
  - ir_valid = !empty; ir_data and ir_npc come from the head entry. Combinational from registered FIFO state; zero extra latency.
  - Pop on ir_valid && ir_ready.
  - Push and pop in the same cycle are legal: count unchanged.
- Empty FIFO: ir_data = NOP_WORD, ir_npc holds its last value.
- Minimum latency, idle to ir_valid: memory latency + 1 cycle (request cycle, response cycle, registered push).
- Redirect (redirect_valid = 1), effective at the end of the cycle:
  - FIFO flushed (count = 0).
  - fetch_pc = resp_pc = redirect_pc.
  - Any pop in that cycle is ignored (consumer treats IR as flushed).
  - A response arriving in that cycle is discarded.
  - drop_cnt = outstanding minus that response if present. outstanding keeps counting real in-flight requests.
  - A second redirect while drop_cnt > 0 recomputes drop_cnt the same way.
- halt: no new issue. Outstanding responses still land and push. The FIFO may still drain via ir_ready.

Test Plan:
1. Reset, halt = 0, memory latency 1, Mem[0..3] = A, B, C, D, ir_ready = 1 -> ir delivers A/1, B/2, C/3, D/4 in order; first ir_valid 2 cycles after reset deassert.
2. ir_ready = 0, memory latency 3 -> exactly 4 requests issued (addrs 0..3), then req_valid = 0 with count = 4. Raise ir_ready -> one new request per pop.
3. Latency 3, redirect_pc = 0x20 pulsed with 2 requests outstanding -> both responses dropped. First delivered entry is Mem[0x20] with npc 0x21; no pre-redirect word is ever presented.
4. Redirect in the same cycle as a response and a pop -> FIFO empty next cycle, ir_data = NOP_WORD, arriving word discarded, drop_cnt = outstanding - 1.
5. fetch_pc = 0x3FF -> next request addr 0x000; entry for 0x3FF has npc 0x400.
6. halt = 1 with 2 outstanding -> 2 more entries pushed, then no requests. Assert reset mid-run -> all outputs at reset values the next cycle.
